// File: rtl/window3x3_linebuf.sv
// ---------------------------------------------------------------------------
// window3x3_linebuf
//
// Turns a raster stream of DATA_W-bit pixels into one 3x3 neighbourhood per
// pixel for the downstream median filter. A delay line of 2*LINE_LEN+3
// samples holds the last two lines plus three pixels. The nine taps sit at
// fixed positions in it. Taps that fall outside the frame are forced to zero.
//
// Ports
//   clk, rst          system clock (rising edge), async active-high reset
//   start             one-cycle pulse, starts a frame (IDLE only)
//   pix_in/pix_valid  input pixel stream, raster order
//   pix_ready         input accepted this cycle when pix_valid is also high
//   win_0..win_8      taps at offsets -L-1,-1,+L-1,-L,0,+L,-L+1,+1,+L+1
//   win_idx           centre pixel index of the presented window
//   win_valid         window valid; out_ready accepts it
//   done              one-cycle pulse after the last window is accepted
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for start
// FILL   | accepting inputs 0..L, no windows yet
// RUN    | each accepted input produces the window centred L+1 behind it
// FLUSH  | shifting in zeros to emit the last L+1 windows
// DONE   | done pulse, back to IDLE
// ---------------------------------------------------------------------------
module window3x3_linebuf #(
    parameter int DATA_W    = 8,
    parameter int LINE_LEN  = 430,
    parameter int NUM_LINES = 554,
    parameter int IDX_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] pix_in,
    input  logic              pix_valid,
    output logic              pix_ready,
    output logic [DATA_W-1:0] win_0,
    output logic [DATA_W-1:0] win_1,
    output logic [DATA_W-1:0] win_2,
    output logic [DATA_W-1:0] win_3,
    output logic [DATA_W-1:0] win_4,
    output logic [DATA_W-1:0] win_5,
    output logic [DATA_W-1:0] win_6,
    output logic [DATA_W-1:0] win_7,
    output logic [DATA_W-1:0] win_8,
    output logic [IDX_W-1:0]  win_idx,
    output logic              win_valid,
    input  logic              out_ready,
    output logic              done
);

    localparam int N      = LINE_LEN * NUM_LINES;
    localparam int DL_LEN = 2 * LINE_LEN + 3;
    localparam int KW     = $clog2(LINE_LEN + 1);
    localparam int LW     = $clog2(NUM_LINES + 1);

    // Position of the centre pixel in the shifted delay line.
    localparam int CP = LINE_LEN + 1;

    localparam logic [IDX_W-1:0] IN_LAST_FILL = IDX_W'(LINE_LEN);
    localparam logic [IDX_W-1:0] IN_LAST      = IDX_W'(N - 1);
    localparam logic [IDX_W-1:0] C_END        = IDX_W'(N);
    localparam logic [KW-1:0]    K_LAST       = KW'(LINE_LEN - 1);
    localparam logic [LW-1:0]    LINE_LAST    = LW'(NUM_LINES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_RUN,
        ST_FLUSH,
        ST_DONE
    } state_t;

    state_t             state_q;
    logic [IDX_W-1:0]   in_cnt_q;
    logic [IDX_W-1:0]   c_cnt_q;
    logic [KW-1:0]      k_q;
    logic [LW-1:0]      line_q;
    logic [DATA_W-1:0]  dl_q  [DL_LEN];
    logic [DATA_W-1:0]  win_q [9];
    logic [IDX_W-1:0]   win_idx_q;
    logic               win_valid_q;
    logic               done_q;

    logic               room;
    logic               in_fire;
    logic               out_fire;
    logic               load;
    logic               shift;
    logic [DATA_W-1:0]  shift_in;
    logic [DATA_W-1:0]  dl_s  [DL_LEN];
    logic [DATA_W-1:0]  tap_d [9];
    logic               k_first;
    logic               k_last;
    logic               line_top;
    logic               line_bot;

    assign room      = !win_valid_q || out_ready;
    assign pix_ready = ((state_q == ST_FILL) || (state_q == ST_RUN)) && room;
    assign in_fire   = pix_valid && pix_ready;
    assign out_fire  = win_valid_q && out_ready;

    // A window is loaded for every RUN input and for every FLUSH step until
    // the centre counter has passed the last pixel.
    assign load  = ((state_q == ST_RUN) && in_fire) ||
                   ((state_q == ST_FLUSH) && room && (c_cnt_q != C_END));
    assign shift = ((state_q == ST_FILL) && in_fire) || load;

    assign shift_in = (state_q == ST_FLUSH) ? '0 : pix_in;

    // Delay line as it will look after this cycle's shift; the window taps
    // are taken from here so the window registers in the same cycle.
    always_comb begin
        dl_s[0] = shift_in;
        for (int j = 1; j < DL_LEN; j++) begin
            dl_s[j] = dl_q[j-1];
        end
    end

    assign k_first  = (k_q == '0);
    assign k_last   = (k_q == K_LAST);
    assign line_top = (line_q == '0);
    assign line_bot = (line_q == LINE_LAST);

    always_comb begin
        tap_d[0] = dl_s[CP + LINE_LEN + 1];
        tap_d[1] = dl_s[CP + 1];
        tap_d[2] = dl_s[CP - LINE_LEN + 1];
        tap_d[3] = dl_s[CP + LINE_LEN];
        tap_d[4] = dl_s[CP];
        tap_d[5] = dl_s[CP - LINE_LEN];
        tap_d[6] = dl_s[CP + LINE_LEN - 1];
        tap_d[7] = dl_s[CP - 1];
        tap_d[8] = dl_s[CP - LINE_LEN - 1];
        // Left and right edges: the neighbouring column belongs to another
        // line in linear memory, so it is blanked rather than wrapped.
        if (k_first) begin
            tap_d[0] = '0;
            tap_d[1] = '0;
            tap_d[2] = '0;
        end
        if (k_last) begin
            tap_d[6] = '0;
            tap_d[7] = '0;
            tap_d[8] = '0;
        end
        if (line_top) begin
            tap_d[0] = '0;
            tap_d[3] = '0;
            tap_d[6] = '0;
        end
        if (line_bot) begin
            tap_d[2] = '0;
            tap_d[5] = '0;
            tap_d[8] = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            in_cnt_q    <= '0;
            c_cnt_q     <= '0;
            k_q         <= '0;
            line_q      <= '0;
            win_idx_q   <= '0;
            win_valid_q <= 1'b0;
            done_q      <= 1'b0;
            for (int j = 0; j < DL_LEN; j++) begin
                dl_q[j] <= '0;
            end
            for (int t = 0; t < 9; t++) begin
                win_q[t] <= '0;
            end
        end else begin
            done_q <= 1'b0;

            if (shift) begin
                for (int j = 0; j < DL_LEN; j++) begin
                    dl_q[j] <= dl_s[j];
                end
            end

            // A new window replaces an accepted one with no bubble.
            if (load) begin
                for (int t = 0; t < 9; t++) begin
                    win_q[t] <= tap_d[t];
                end
                win_idx_q   <= c_cnt_q;
                win_valid_q <= 1'b1;
                c_cnt_q     <= c_cnt_q + 1'b1;
                if (k_last) begin
                    k_q    <= '0;
                    line_q <= line_q + 1'b1;
                end else begin
                    k_q <= k_q + 1'b1;
                end
            end else if (out_fire) begin
                win_valid_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        in_cnt_q <= '0;
                        c_cnt_q  <= '0;
                        k_q      <= '0;
                        line_q   <= '0;
                        state_q  <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (in_fire) begin
                        in_cnt_q <= in_cnt_q + 1'b1;
                        if (in_cnt_q == IN_LAST_FILL) begin
                            state_q <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (in_fire) begin
                        in_cnt_q <= in_cnt_q + 1'b1;
                        if (in_cnt_q == IN_LAST) begin
                            state_q <= ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: begin
                    // Every window has been loaded once the centre counter
                    // reaches N; finish when the last one is taken.
                    if ((c_cnt_q == C_END) && out_fire) begin
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign win_0     = win_q[0];
    assign win_1     = win_q[1];
    assign win_2     = win_q[2];
    assign win_3     = win_q[3];
    assign win_4     = win_q[4];
    assign win_5     = win_q[5];
    assign win_6     = win_q[6];
    assign win_7     = win_q[7];
    assign win_8     = win_q[8];
    assign win_idx   = win_idx_q;
    assign win_valid = win_valid_q;
    assign done      = done_q;

endmodule

// File: tb/tb_window3x3_linebuf.sv
// Bench for window3x3_linebuf with a 4x3 frame; pixel i carries value i+1.
module tb_window3x3_linebuf;

    localparam int DW = 8;
    localparam int L  = 4;
    localparam int NL = 3;
    localparam int N  = L * NL;
    localparam int IW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [DW-1:0] pix_in;
    logic          pix_valid;
    logic          pix_ready;
    logic [DW-1:0] win_0, win_1, win_2, win_3, win_4, win_5, win_6, win_7, win_8;
    logic [IW-1:0] win_idx;
    logic          win_valid;
    logic          out_ready;
    logic          done;
    logic [71:0]   win_all;

    window3x3_linebuf #(
        .DATA_W(DW), .LINE_LEN(L), .NUM_LINES(NL), .IDX_W(IW)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .win_0(win_0), .win_1(win_1), .win_2(win_2), .win_3(win_3),
        .win_4(win_4), .win_5(win_5), .win_6(win_6), .win_7(win_7),
        .win_8(win_8), .win_idx(win_idx), .win_valid(win_valid),
        .out_ready(out_ready), .done(done)
    );

    assign win_all = {win_0, win_1, win_2, win_3, win_4, win_5, win_6, win_7, win_8};

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Window/done recorder, sampled mid-cycle.
    logic [71:0] got_win [$];
    int          got_idx [$];
    int          got_cyc [$];
    bit          mon_en;
    bit          all_in;
    int          done_cnt;
    int          done_cyc;
    int          first_vcyc;
    int          ready_flush_bad;
    int          in5_cyc;

    always @(negedge clk) begin
        if (mon_en && win_valid && out_ready) begin
            got_win.push_back(win_all);
            got_idx.push_back(int'(win_idx));
            got_cyc.push_back(cyc);
        end
        if (mon_en && win_valid && first_vcyc < 0) first_vcyc = cyc;
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (mon_en && all_in && pix_ready) ready_flush_bad = ready_flush_bad + 1;
    end

    // Expected window from frame coordinates (row/column with bounds).
    function automatic logic [71:0] exp_win(input int c);
        int dr [9];
        int dc [9];
        int r, col, rr, cc;
        logic [71:0] w;
        logic [7:0]  v;
        dr = '{-1, 0, 1, -1, 0, 1, -1, 0, 1};
        dc = '{-1, -1, -1, 0, 0, 0, 1, 1, 1};
        r   = c / L;
        col = c % L;
        w   = '0;
        for (int t = 0; t < 9; t++) begin
            rr = r + dr[t];
            cc = col + dc[t];
            if (rr >= 0 && rr < NL && cc >= 0 && cc < L) v = 8'(rr * L + cc + 1);
            else v = 8'd0;
            w = {w[63:0], v};
        end
        return w;
    endfunction

    task automatic clear_mon();
        got_win.delete();
        got_idx.delete();
        got_cyc.delete();
        all_in          = 1'b0;
        done_cnt        = 0;
        done_cyc        = -1;
        first_vcyc      = -1;
        ready_flush_bad = 0;
        in5_cyc         = -1;
        mon_en          = 1'b1;
    endtask

    // Starts a frame and pushes all N pixels; gap=1 toggles pix_valid.
    task automatic drive_frame(input bit gap);
        int  i = 0;
        int  g = 0;
        bit  ph = 1'b1;
        bit  acc;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        while (i < N && g < 2000) begin
            pix_in    = 8'(i + 1);
            pix_valid = gap ? ph : 1'b1;
            @(negedge clk);
            acc = pix_valid && pix_ready;
            @(posedge clk); #1;
            if (acc) begin
                if (i == L + 1) in5_cyc = cyc;
                i++;
            end
            ph = !ph;
            g++;
        end
        pix_valid = 1'b0;
        all_in    = 1'b1;
        checks++;
        if (i != N) begin
            failures++;
            $display("FAIL drive_inputs: accepted %0d, required %0d", i, N);
        end
    endtask

    task automatic wait_done();
        int g = 0;
        while (done_cnt == 0 && g < 200) begin
            @(negedge clk);
            g++;
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; pix_valid = 1'b0; pix_in = '0; out_ready = 1'b1;
        mon_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (pix_ready !== 1'b0) begin failures++; $display("FAIL reset_pix_ready: got %b want 0", pix_ready); end
        checks++;
        if (win_valid !== 1'b0) begin failures++; $display("FAIL reset_win_valid: got %b want 0", win_valid); end
        checks++;
        if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", done); end
        checks++;
        if (win_all !== 72'd0) begin failures++; $display("FAIL reset_win: got %h want 0", win_all); end
        checks++;
        if (win_idx !== 32'd0) begin failures++; $display("FAIL reset_win_idx: got %0d want 0", win_idx); end
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_frame(input string tag);
        logic [71:0] c0, c5, c11;
        c0  = {8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd5, 8'd0, 8'd2, 8'd6};
        c5  = {8'd1, 8'd5, 8'd9, 8'd2, 8'd6, 8'd10, 8'd3, 8'd7, 8'd11};
        c11 = {8'd7, 8'd11, 8'd0, 8'd8, 8'd12, 8'd0, 8'd0, 8'd0, 8'd0};
        clear_mon();
        out_ready = 1'b1;
        drive_frame(1'b0);
        wait_done();
        mon_en = 1'b0;
        checks++;
        if (got_win.size() != N) begin
            failures++;
            $display("FAIL %s_count: got %0d windows want %0d", tag, got_win.size(), N);
        end
        checks++;
        if (first_vcyc != in5_cyc || in5_cyc < 0) begin
            failures++;
            $display("FAIL %s_latency: first valid cycle %0d, input 5 cycle %0d", tag, first_vcyc, in5_cyc);
        end
        if (got_win.size() == N) begin
            checks++;
            if (got_idx[0] != 0 || got_win[0] !== c0) begin
                failures++;
                $display("FAIL %s_corner: idx %0d win %h want idx 0 win %h", tag, got_idx[0], got_win[0], c0);
            end
            checks++;
            if (got_win[5] !== c5) begin
                failures++;
                $display("FAIL %s_interior: got %h want %h", tag, got_win[5], c5);
            end
            checks++;
            if (got_win[11] !== c11) begin
                failures++;
                $display("FAIL %s_last: got %h want %h", tag, got_win[11], c11);
            end
            for (int j = 0; j < N; j++) begin
                checks++;
                if (got_idx[j] != j || got_win[j] !== exp_win(j)) begin
                    failures++;
                    $display("FAIL %s_win%0d: idx %0d win %h want idx %0d win %h",
                             tag, j, got_idx[j], got_win[j], j, exp_win(j));
                end
            end
            checks++;
            if (done_cyc != got_cyc[N-1] + 1) begin
                failures++;
                $display("FAIL %s_done_timing: done cycle %0d, want %0d", tag, done_cyc, got_cyc[N-1] + 1);
            end
        end
        checks++;
        if (done_cnt != 1) begin
            failures++;
            $display("FAIL %s_done_count: got %0d want 1", tag, done_cnt);
        end
        checks++;
        if (ready_flush_bad != 0) begin
            failures++;
            $display("FAIL %s_flush_ready: pix_ready high %0d cycles, want 0", tag, ready_flush_bad);
        end
    endtask

    task automatic test_backpressure();
        logic [71:0] c3;
        c3 = {8'd0, 8'd3, 8'd7, 8'd0, 8'd4, 8'd8, 8'd0, 8'd0, 8'd0};
        clear_mon();
        out_ready = 1'b1;
        fork
            drive_frame(1'b0);
            begin
                int g = 0;
                while (!(win_valid && win_idx == 32'd3) && g < 500) begin
                    @(posedge clk); #1;
                    g++;
                end
                out_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    @(negedge clk);
                    checks++;
                    if (win_valid !== 1'b1 || win_idx !== 32'd3 || win_all !== c3 || pix_ready !== 1'b0) begin
                        failures++;
                        $display("FAIL bp_stall%0d: valid %b idx %0d win %h ready %b want 1 3 %h 0",
                                 s, win_valid, win_idx, win_all, pix_ready, c3);
                    end
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
                @(posedge clk); #1;
                checks++;
                if (win_valid !== 1'b1 || win_idx !== 32'd4) begin
                    failures++;
                    $display("FAIL bp_resume: valid %b idx %0d want 1 4", win_valid, win_idx);
                end
            end
        join
        wait_done();
        mon_en = 1'b0;
        checks++;
        if (got_win.size() != N) begin
            failures++;
            $display("FAIL bp_count: got %0d windows want %0d", got_win.size(), N);
        end else begin
            for (int j = 0; j < N; j++) begin
                checks++;
                if (got_idx[j] != j || got_win[j] !== exp_win(j)) begin
                    failures++;
                    $display("FAIL bp_win%0d: idx %0d win %h want %h", j, got_idx[j], got_win[j], exp_win(j));
                end
            end
        end
        checks++;
        if (done_cnt != 1) begin failures++; $display("FAIL bp_done: got %0d want 1", done_cnt); end
    endtask

    task automatic test_gapped();
        clear_mon();
        out_ready = 1'b1;
        drive_frame(1'b1);
        wait_done();
        mon_en = 1'b0;
        checks++;
        if (got_win.size() != N) begin
            failures++;
            $display("FAIL gap_count: got %0d windows want %0d", got_win.size(), N);
        end else begin
            for (int j = 0; j < N; j++) begin
                checks++;
                if (got_idx[j] != j || got_win[j] !== exp_win(j)) begin
                    failures++;
                    $display("FAIL gap_win%0d: idx %0d win %h want %h", j, got_idx[j], got_win[j], exp_win(j));
                end
            end
        end
        checks++;
        if (done_cnt != 1) begin failures++; $display("FAIL gap_done: got %0d want 1", done_cnt); end
    endtask

    task automatic test_reset_midframe();
        int i = 0;
        int g = 0;
        bit acc;
        clear_mon();
        mon_en    = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        while (!(win_valid && win_idx == 32'd7) && g < 200) begin
            pix_in    = 8'(i + 1);
            pix_valid = 1'b1;
            @(negedge clk);
            acc = pix_ready;
            @(posedge clk); #1;
            if (acc) i++;
            g++;
        end
        checks++;
        if (g >= 200) begin failures++; $display("FAIL mid_reach_c7: timed out, idx %0d", win_idx); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (win_valid !== 1'b0 || pix_ready !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_flags: valid %b ready %b done %b want 0 0 0", win_valid, pix_ready, done);
        end
        checks++;
        if (win_all !== 72'd0 || win_idx !== 32'd0) begin
            failures++;
            $display("FAIL mid_reset_data: win %h idx %0d want 0 0", win_all, win_idx);
        end
        pix_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (done_cnt != 0) begin failures++; $display("FAIL mid_no_done: got %0d pulses want 0", done_cnt); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_frame("frame");
        test_backpressure();
        test_gapped();
        test_reset_midframe();
        test_frame("after_reset");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
